// File: rtl/vedic_seq_mul_ctrl.sv
// Sequential DW x DW unsigned multiplier: one 4x4 Vedic core walks every digit pair
// of the registered operands and shift-accumulates the partial products.
`timescale 1ns/1ps
module vedic_seq_mul_ctrl #(
    parameter int DW = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [DW-1:0]   a,
    input  logic [DW-1:0]   b,
    input  logic            in_valid,
    output logic            in_ready,
    output logic [2*DW-1:0] product,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            busy
);

    localparam int DIG = DW / 4;
    localparam int CW  = (DIG > 1) ? $clog2(DIG) : 1;
    localparam logic [CW-1:0] DMAX = CW'(DIG - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t            r_state;
    state_t            w_next;
    logic [DW-1:0]     r_a;
    logic [DW-1:0]     r_b;
    logic [2*DW-1:0]   r_acc;
    logic [2*DW-1:0]   r_product;
    logic [CW-1:0]     r_di;
    logic [CW-1:0]     r_dj;
    logic [3:0]        w_adig;
    logic [3:0]        w_bdig;
    logic [7:0]        w_pp;
    logic [CW:0]       w_dsum;
    logic [2*DW-1:0]   w_term;
    logic [2*DW-1:0]   w_sum;
    logic              w_last;

    // Vertically-and-crosswise 2x2 cell: the two cross terms only carry when both are set.
    function automatic logic [3:0] vedic2x2(input logic [1:0] x, input logic [1:0] y);
        logic [3:0] p;
        logic       c1;
        p[0] = x[0] & y[0];
        p[1] = (x[1] & y[0]) ^ (x[0] & y[1]);
        c1   = (x[1] & y[0]) & (x[0] & y[1]);
        p[2] = (x[1] & y[1]) ^ c1;
        p[3] = (x[1] & y[1]) & c1;
        return p;
    endfunction

    function automatic logic [7:0] vedic4x4(input logic [3:0] x, input logic [3:0] y);
        logic [3:0] q0, q1, q2, q3;
        q0 = vedic2x2(x[1:0], y[1:0]);
        q1 = vedic2x2(x[3:2], y[1:0]);
        q2 = vedic2x2(x[1:0], y[3:2]);
        q3 = vedic2x2(x[3:2], y[3:2]);
        return {4'b0, q0} + {2'b0, q1, 2'b0} + {2'b0, q2, 2'b0} + {q3, 4'b0};
    endfunction

    assign w_adig = r_a[{r_di, 2'b00} +: 4];
    assign w_bdig = r_b[{r_dj, 2'b00} +: 4];
    assign w_pp   = vedic4x4(w_adig, w_bdig);
    assign w_dsum = {1'b0, r_di} + {1'b0, r_dj};
    assign w_term = {{(2*DW-8){1'b0}}, w_pp} << {w_dsum, 2'b00};
    assign w_sum  = r_acc + w_term;
    assign w_last = (r_di == DMAX) && (r_dj == DMAX);

    assign in_ready  = (r_state == IDLE);
    assign busy      = (r_state != IDLE);
    assign out_valid = (r_state == DONE);
    assign product   = r_product;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (in_valid)  w_next = RUN;
            RUN:     if (w_last)    w_next = DONE;
            DONE:    if (out_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Datapath: capture in IDLE, one digit pair per RUN edge (a-digit index is the fast one).
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a       <= '0;
            r_b       <= '0;
            r_acc     <= '0;
            r_product <= '0;
            r_di      <= '0;
            r_dj      <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_a   <= a;
                        r_b   <= b;
                        r_acc <= '0;
                        r_di  <= '0;
                        r_dj  <= '0;
                    end
                end
                RUN: begin
                    r_acc <= w_sum;
                    if (r_di == DMAX) begin
                        r_di <= '0;
                        r_dj <= (r_dj == DMAX) ? '0 : r_dj + 1'b1;
                    end else begin
                        r_di <= r_di + 1'b1;
                    end
                    if (w_last) begin
                        r_product <= w_sum;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
